// File: rtl/sci_pcs_access_sequencer.sv
// Turns the JTAG SCI hub's flat command bus into timed strobes on one PCS quad SCI port.
// Requests are edge/address-change detected, decoded, queued in a one-deep slot and sequenced.
module sci_pcs_access_sequencer #(
    parameter logic [8:0] QUAD_ID   = 9'd0,
    parameter int         WR_PULSE  = 2,
    parameter int         RD_LAT    = 2,
    parameter logic [7:0] INV_RDATA = 8'hFF
) (
    input  logic        jtck,
    input  logic        rstn,
    input  logic [17:0] sciaddr,
    input  logic [7:0]  sciwdata,
    input  logic        sciwstn,
    input  logic        scird,
    output logic [7:0]  scirmxdata,
    output logic [5:0]  pcs_sciaddr,
    output logic [7:0]  pcs_sciwdata,
    output logic [3:0]  pcs_sciselch,
    output logic        pcs_sciselaux,
    output logic        pcs_sciwstn,
    output logic        pcs_scird,
    input  logic [7:0]  pcs_scirdata,
    output logic        busy,
    output logic        err_sel,
    output logic        err_ovf
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_WSTB  = 3'd2;
    localparam logic [2:0] ST_RSTB  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    // Counters load N-1 so the strobe lasts exactly N cycles.
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_PULSE - 1);
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);

    function automatic logic [3:0] sel_onehot(input logic [2:0] sel);
        logic [3:0] oh;
        case (sel)
            3'd0:    oh = 4'b0001;
            3'd1:    oh = 4'b0010;
            3'd2:    oh = 4'b0100;
            3'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic logic sel_valid(input logic [2:0] sel);
        return (sel <= 3'd4);
    endfunction

    logic [2:0]  state_r;
    logic [3:0]  cnt_r;
    logic        wr_d_r;
    logic        rd_d_r;
    logic [17:0] last_rd_addr_r;
    logic [2:0]  cur_sel_r;
    logic        cur_wr_r;
    logic        pend_v_r;
    logic [8:0]  pend_addr_r;
    logic [7:0]  pend_wdata_r;
    logic        pend_wr_r;
    logic [7:0]  rmx_r;
    logic [5:0]  paddr_r;
    logic [7:0]  pwdata_r;
    logic [3:0]  selch_r;
    logic        selaux_r;
    logic        wstn_r;
    logic        rd_r;
    logic        busy_r;
    logic        err_sel_r;
    logic        err_ovf_r;

    logic        wr_ok_s;
    logic        rd_ok_s;
    logic        new_v_s;
    logic        idle_like_s;
    logic        launch_s;
    logic        launch_pend_s;
    logic        store_s;
    logic        drop_s;
    logic        collide_s;
    logic        rd_acc_s;
    logic        sel_err_s;
    logic [8:0]  l_addr_s;
    logic [7:0]  l_wdata_s;
    logic        l_wr_s;

    // Request detection, slot arbitration and launch source selection.
    always_comb begin
        wr_ok_s       = 1'b0;
        rd_ok_s       = 1'b0;
        if (sciaddr[17:9] == QUAD_ID) begin
            wr_ok_s = sciwstn & ~wr_d_r;
            rd_ok_s = scird & (~rd_d_r | (sciaddr != last_rd_addr_r));
        end else begin
            wr_ok_s = 1'b0;
            rd_ok_s = 1'b0;
        end
        new_v_s       = wr_ok_s | rd_ok_s;
        collide_s     = wr_ok_s & rd_ok_s;
        // HOLD behaves like IDLE for launching so back-to-back accesses have no gap.
        idle_like_s   = (state_r == ST_IDLE) | (state_r == ST_HOLD);
        launch_pend_s = idle_like_s & pend_v_r;
        launch_s      = idle_like_s & (pend_v_r | new_v_s);
        store_s       = new_v_s & ((~idle_like_s & ~pend_v_r) | (idle_like_s & pend_v_r));
        drop_s        = new_v_s & ~idle_like_s & pend_v_r;
        rd_acc_s      = rd_ok_s & ~wr_ok_s & ~drop_s;
        sel_err_s     = (state_r == ST_SETUP) & ~sel_valid(cur_sel_r);
        if (launch_pend_s) begin
            l_addr_s  = pend_addr_r;
            l_wdata_s = pend_wdata_r;
            l_wr_s    = pend_wr_r;
        end else begin
            l_addr_s  = sciaddr[8:0];
            l_wdata_s = sciwdata;
            l_wr_s    = wr_ok_s;
        end
    end

    // Edge-detect history and the address of the last accepted read.
    always_ff @(posedge jtck or negedge rstn) begin
        if (!rstn) begin
            wr_d_r         <= 1'b0;
            rd_d_r         <= 1'b0;
            last_rd_addr_r <= 18'd0;
        end else begin
            wr_d_r <= sciwstn;
            rd_d_r <= scird;
            if (rd_acc_s) begin
                last_rd_addr_r <= sciaddr;
            end
        end
    end

    // One-deep pending request slot.
    always_ff @(posedge jtck or negedge rstn) begin
        if (!rstn) begin
            pend_v_r     <= 1'b0;
            pend_addr_r  <= 9'd0;
            pend_wdata_r <= 8'd0;
            pend_wr_r    <= 1'b0;
        end else if (store_s) begin
            pend_v_r     <= 1'b1;
            pend_addr_r  <= sciaddr[8:0];
            pend_wdata_r <= sciwdata;
            pend_wr_r    <= wr_ok_s;
        end else if (launch_pend_s) begin
            pend_v_r <= 1'b0;
        end
    end

    // Sticky error flags and the busy indication.
    always_ff @(posedge jtck or negedge rstn) begin
        if (!rstn) begin
            err_sel_r <= 1'b0;
            err_ovf_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            err_sel_r <= err_sel_r | sel_err_s;
            err_ovf_r <= err_ovf_r | collide_s | drop_s;
            busy_r    <= (state_r != ST_IDLE) | pend_v_r | launch_s;
        end
    end

    // Access sequencer: drives the PCS address, select and strobes and captures read data.
    always_ff @(posedge jtck or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            cur_sel_r <= 3'd0;
            cur_wr_r  <= 1'b0;
            rmx_r     <= 8'h00;
            paddr_r   <= 6'd0;
            pwdata_r  <= 8'd0;
            selch_r   <= 4'd0;
            selaux_r  <= 1'b0;
            wstn_r    <= 1'b1;
            rd_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (launch_s) begin
                        state_r   <= ST_SETUP;
                        paddr_r   <= l_addr_s[5:0];
                        pwdata_r  <= l_wdata_s;
                        selch_r   <= sel_onehot(l_addr_s[8:6]);
                        selaux_r  <= (l_addr_s[8:6] == 3'd4);
                        cur_sel_r <= l_addr_s[8:6];
                        cur_wr_r  <= l_wr_s;
                    end else begin
                        state_r  <= ST_IDLE;
                        selch_r  <= 4'd0;
                        selaux_r <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (!sel_valid(cur_sel_r)) begin
                        state_r <= ST_HOLD;
                        if (!cur_wr_r) begin
                            rmx_r <= INV_RDATA;
                        end
                    end else if (cur_wr_r) begin
                        state_r <= ST_WSTB;
                        cnt_r   <= WR_CNT_INIT;
                        wstn_r  <= 1'b0;
                    end else begin
                        state_r <= ST_RSTB;
                        cnt_r   <= RD_CNT_INIT;
                        rd_r    <= 1'b1;
                    end
                end
                ST_WSTB: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_HOLD;
                        wstn_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RSTB: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_HOLD;
                        rd_r    <= 1'b0;
                        rmx_r   <= pcs_scirdata;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    wstn_r   <= 1'b1;
                    rd_r     <= 1'b0;
                    selch_r  <= 4'd0;
                    selaux_r <= 1'b0;
                end
            endcase
        end
    end

    assign scirmxdata    = rmx_r;
    assign pcs_sciaddr   = paddr_r;
    assign pcs_sciwdata  = pwdata_r;
    assign pcs_sciselch  = selch_r;
    assign pcs_sciselaux = selaux_r;
    assign pcs_sciwstn   = wstn_r;
    assign pcs_scird     = rd_r;
    assign busy          = busy_r;
    assign err_sel       = err_sel_r;
    assign err_ovf       = err_ovf_r;

endmodule

// File: tb/tb_sci_pcs_access_sequencer.sv
// Directed bench for sci_pcs_access_sequencer: a scoreboard checks every PCS strobe
// against queued expectations while the stimulus thread also checks levels and flags.
module tb_sci_pcs_access_sequencer;

    logic        jtck = 1'b0;
    logic        rstn;
    logic [17:0] sciaddr;
    logic [7:0]  sciwdata;
    logic        sciwstn;
    logic        scird;
    logic [7:0]  scirmxdata;
    logic [5:0]  pcs_sciaddr;
    logic [7:0]  pcs_sciwdata;
    logic [3:0]  pcs_sciselch;
    logic        pcs_sciselaux;
    logic        pcs_sciwstn;
    logic        pcs_scird;
    logic [7:0]  pcs_scirdata;
    logic        busy;
    logic        err_sel;
    logic        err_ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic       kind;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [3:0] selch;
        logic       selaux;
        int         start;
        int         len;
        logic [7:0] rdata;
    } exp_t;

    exp_t q[$];

    sci_pcs_access_sequencer dut (
        .jtck(jtck), .rstn(rstn), .sciaddr(sciaddr), .sciwdata(sciwdata),
        .sciwstn(sciwstn), .scird(scird), .scirmxdata(scirmxdata),
        .pcs_sciaddr(pcs_sciaddr), .pcs_sciwdata(pcs_sciwdata),
        .pcs_sciselch(pcs_sciselch), .pcs_sciselaux(pcs_sciselaux),
        .pcs_sciwstn(pcs_sciwstn), .pcs_scird(pcs_scird),
        .pcs_scirdata(pcs_scirdata), .busy(busy), .err_sel(err_sel), .err_ovf(err_ovf)
    );

    always #5 jtck = ~jtck;

    always @(posedge jtck) cyc <= cyc + 1;

    function automatic logic [51:0] pack(input exp_t e);
        return {e.kind, e.addr, e.wdata, e.selch, e.selaux, e.start[15:0], e.len[7:0], e.rdata};
    endfunction

    task automatic push_exp(input logic kind, input logic [5:0] addr, input logic [7:0] wdata,
                            input logic [3:0] selch, input logic selaux, input int start,
                            input int len, input logic [7:0] rdata);
        exp_t e;
        e.kind = kind; e.addr = addr; e.wdata = wdata; e.selch = selch;
        e.selaux = selaux; e.start = start; e.len = len; e.rdata = rdata;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input exp_t act);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: got %h expected none", pack(act));
        end else begin
            e = q.pop_front();
            if (pack(act) !== pack(e)) begin
                bad++;
                $display("FAIL strobe: got %h expected %h", pack(act), pack(e));
            end
        end
    endtask

    // Monitor: measures each PCS strobe and scores it when it ends.
    initial begin
        exp_t w;
        exp_t r;
        logic in_w = 1'b0;
        logic in_r = 1'b0;
        forever begin
            @(negedge jtck);
            if (!rstn) begin
                in_w = 1'b0;
                in_r = 1'b0;
            end else begin
                if (pcs_sciwstn === 1'b0) begin
                    if (!in_w) begin
                        in_w = 1'b1;
                        w.kind = 1'b0; w.addr = pcs_sciaddr; w.wdata = pcs_sciwdata;
                        w.selch = pcs_sciselch; w.selaux = pcs_sciselaux;
                        w.start = cyc; w.len = 1; w.rdata = 8'h00;
                    end else begin
                        w.len++;
                    end
                end else if (in_w) begin
                    in_w = 1'b0;
                    score(w);
                end
                if (pcs_scird === 1'b1) begin
                    if (!in_r) begin
                        in_r = 1'b1;
                        r.kind = 1'b1; r.addr = pcs_sciaddr; r.wdata = pcs_sciwdata;
                        r.selch = pcs_sciselch; r.selaux = pcs_sciselaux;
                        r.start = cyc; r.len = 1; r.rdata = 8'h00;
                    end else begin
                        r.len++;
                    end
                end else if (in_r) begin
                    in_r = 1'b0;
                    r.rdata = scirmxdata;
                    score(r);
                end
            end
        end
    end

    task automatic step();
        @(posedge jtck);
        #1;
    endtask

    task automatic step_to(input int target);
        for (int k = 0; k < 64 && cyc < target; k++) step();
    endtask

    initial begin
        int n;
        rstn = 1'b0; sciaddr = 18'd0; sciwdata = 8'd0; sciwstn = 1'b0; scird = 1'b0;
        pcs_scirdata = 8'h00;
        step(); step();
        chk("rst_rmx", 32'(scirmxdata), 32'h00);
        chk("rst_wstn", 32'(pcs_sciwstn), 32'h1);
        chk("rst_rd", 32'(pcs_scird), 32'h0);
        chk("rst_flags", 32'({busy, err_sel, err_ovf, pcs_sciselaux, pcs_sciselch}), 32'h0);
        rstn = 1'b1;
        step(); step();

        // Write, sel 2 reg 5
        sciaddr = 18'h00085; sciwdata = 8'h3C; sciwstn = 1'b1; n = cyc;
        push_exp(1'b0, 6'h05, 8'h3C, 4'b0100, 1'b0, n + 2, 2, 8'h00);
        step(); sciwstn = 1'b0;
        chk("wr_setup", 32'({pcs_sciselch, pcs_sciaddr, pcs_sciwdata, busy}), 32'({4'b0100, 6'h05, 8'h3C, 1'b1}));
        step_to(n + 5);
        chk("wr_sel_clr", 32'({pcs_sciselch, busy}), 32'({4'b0000, 1'b1}));
        step_to(n + 6);
        chk("wr_busy_low", 32'(busy), 32'h0);

        // Read, aux reg 12, then address change with scird held
        pcs_scirdata = 8'hA7; sciaddr = 18'h00112; scird = 1'b1; n = cyc;
        push_exp(1'b1, 6'h12, 8'h3C, 4'b0000, 1'b1, n + 2, 2, 8'hA7);
        step_to(n + 1);
        chk("rd_aux", 32'(pcs_sciselaux), 32'h1);
        step_to(n + 4);
        chk("rd_data", 32'(scirmxdata), 32'hA7);
        step_to(n + 7);
        pcs_scirdata = 8'h5E; sciaddr = 18'h00113; n = cyc;
        push_exp(1'b1, 6'h13, 8'h3C, 4'b0000, 1'b1, n + 2, 2, 8'h5E);
        step(); scird = 1'b0;
        step_to(n + 4);
        chk("rd2_data", 32'(scirmxdata), 32'h5E);
        step_to(n + 7);

        // Quad mismatch: ignored entirely
        sciaddr = 18'h00285; sciwstn = 1'b1;
        step();
        chk("quad_busy", 32'({busy, pcs_sciselch}), 32'h0);
        step(); step(); step(); sciwstn = 1'b0;
        chk("quad_idle", 32'({busy, pcs_sciwstn, err_sel, err_ovf}), 32'({1'b0, 1'b1, 1'b0, 1'b0}));

        // Invalid selector 6 read
        sciaddr = 18'h00181; scird = 1'b1; n = cyc;
        step_to(n + 2);
        chk("inv_rdata", 32'(scirmxdata), 32'hFF);
        chk("inv_flags", 32'({err_sel, err_ovf, pcs_sciselch, pcs_sciselaux}), 32'({1'b1, 1'b0, 4'b0000, 1'b0}));
        scird = 1'b0;
        step_to(n + 6);

        // Back-to-back: write, read (pending), write (dropped)
        pcs_scirdata = 8'hC3; sciaddr = 18'h0004A; sciwdata = 8'h55; sciwstn = 1'b1; n = cyc;
        push_exp(1'b0, 6'h0A, 8'h55, 4'b0010, 1'b0, n + 2, 2, 8'h00);
        step();
        sciwstn = 1'b0; scird = 1'b1; sciaddr = 18'h000E1; sciwdata = 8'h66;
        push_exp(1'b1, 6'h21, 8'h66, 4'b1000, 1'b0, n + 6, 2, 8'hC3);
        step();
        scird = 1'b0; sciwstn = 1'b1; sciaddr = 18'h00003; sciwdata = 8'h77;
        step();
        sciwstn = 1'b0;
        chk("ovf_set", 32'(err_ovf), 32'h1);
        step_to(n + 8);
        chk("b2b_rdata", 32'(scirmxdata), 32'hC3);
        step_to(n + 11);
        chk("b2b_idle", 32'(busy), 32'h0);

        // Reset during write strobe
        sciaddr = 18'h00003; sciwdata = 8'h99; sciwstn = 1'b1; n = cyc;
        step(); sciwstn = 1'b0;
        step();
        chk("mid_wstb", 32'(pcs_sciwstn), 32'h0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_abort", 32'({pcs_sciwstn, busy, pcs_sciselch, err_ovf}), 32'({1'b1, 1'b0, 4'b0000, 1'b0}));
        step(); rstn = 1'b1;
        step();
        sciaddr = 18'h00087; sciwdata = 8'hA5; sciwstn = 1'b1; n = cyc;
        push_exp(1'b0, 6'h07, 8'hA5, 4'b0100, 1'b0, n + 2, 2, 8'h00);
        step(); sciwstn = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'h1);
        step_to(n + 7);
        chk("post_rst_idle", 32'(busy), 32'h0);

        chk("sb_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sci_pcs_access_sequencer.md
Name: sci_pcs_access_sequencer

Overview:
- Sits directly downstream of the JTAG SCI hub, on the same jtck domain.
- Converts the hub's flat SCI command bus into timed accesses on one ECP3/XP2 PCS quad's SCI port:
  - sciaddr, sciwdata, sciwstn (high = write request), scird (high = read request).
- Decodes quad, channel and register fields, generates the PCS strobes, and captures read data.
- Returns read data to the hub on scirmxdata.

Parameters:
- QUAD_ID, 9'd0: value sciaddr[17:9] must match for this block to respond.
- WR_PULSE, 2: cycles pcs_sciwstn is held low per write (1..15).
- RD_LAT, 2: cycles pcs_scird is held high before pcs_scirdata is sampled (1..15).
- INV_RDATA, 8'hFF: data returned for a read to an invalid selector.

Ports:
- jtck, in, 1: sole clock; all logic on posedge.
- rstn, in, 1: asynchronous active-low reset.
- sciaddr, in, 18: [17:9] quad, [8:6] selector, [5:0] register address.
- sciwdata, in, 8: write data.
- sciwstn, in, 1: write request level; a rising edge starts a write.
- scird, in, 1: read request level.
- scirmxdata, out, 8: last read result, held until the next read completes.
- pcs_sciaddr, out, 6: PCS register address.
- pcs_sciwdata, out, 8: PCS write data.
- pcs_sciselch, out, 4: one-hot channel select.
- pcs_sciselaux, out, 1: aux block select.
- pcs_sciwstn, out, 1: PCS write strobe, active low.
- pcs_scird, out, 1: PCS read strobe, active high.
- pcs_scirdata, in, 8: PCS read data.
- busy, out, 1: access in progress or pending.
- err_sel, out, 1: sticky; set by an access to selector 5..7.
- err_ovf, out, 1: sticky; set when a request is dropped.

Behaviour:
- Reset state (asynchronous, active low):
  - scirmxdata=8'h00; pcs_sciaddr=0; pcs_sciwdata=0; pcs_sciselch=0; pcs_sciselaux=0.
  - pcs_sciwstn=1; pcs_scird=0; busy=0; err_sel=0; err_ovf=0.
  - Edge-detect registers=0; last_rd_addr=0; pending empty; FSM=IDLE.
  - Reset asserted mid-access aborts immediately; no strobe survives reset.
- Request detection, on cycle N:
  - Write request: sciwstn=1 at N and 0 at N-1.
  - Read request: scird=1 and either (scird=0 at N-1) or (sciaddr != last_rd_addr).
  - last_rd_addr updates on every accepted read.
  - A request with sciaddr[17:9] != QUAD_ID is ignored entirely: no strobes, no flags.
  - A simultaneous write and read request on the same cycle: the write is accepted and the read is dropped, setting err_ovf.
- Command latch: sciaddr and sciwdata are latched at N.
- Selector decode:
  - 0..3: pcs_sciselch = one-hot(sel).
  - 4: pcs_sciselaux = 1.
  - 5..7: no select asserted, no strobe, err_sel set.
    - A read returns INV_RDATA on scirmxdata at N+2.
    - A write is discarded.
- FSM states: IDLE, SETUP, WSTB, RSTB, HOLD.
  - IDLE -> SETUP on a valid request, or on a pending request.
  - SETUP, cycle N+1: drive pcs_sciaddr, pcs_sciwdata and the select; busy=1.
  - WSTB, cycles N+2 .. N+1+WR_PULSE: pcs_sciwstn=0.
  - RSTB, cycles N+2 .. N+1+RD_LAT: pcs_scird=1.
    - pcs_scirdata is sampled at the posedge ending the last RSTB cycle.
    - scirmxdata updates at N+2+RD_LAT.
  - HOLD, one cycle: strobes inactive, address and select still held.
  - HOLD -> IDLE: selects cleared the cycle after HOLD.
  - HOLD -> SETUP: if a request is pending, the next access starts with no idle gap.
- Pending slot (depth 1):
  - A request detected while FSM != IDLE is stored, with its address and data captured at detection.
  - A further request while the slot is full is dropped and sets err_ovf.
- busy = (FSM != IDLE) | pending.
- err_sel and err_ovf clear only on reset.
- Strobe counters are 4-bit; WR_PULSE and RD_LAT of 0 are illegal.

Test Plan:
- Write, defaults: sciaddr=18'h00085 (quad 0, sel 2, reg 5), sciwdata=8'h3C, sciwstn rises at N.
  - pcs_sciselch=4'b0100, pcs_sciaddr=6'h05, pcs_sciwdata=8'h3C from N+1.
  - pcs_sciwstn low at N+2..N+3; busy low at N+6.
- Read: sel 4, reg 6'h12, scird rises at N, pcs_scirdata=8'hA7.
  - pcs_sciselaux=1; pcs_scird high N+2..N+3; scirmxdata=8'hA7 at N+4.
  - Then change sciaddr to reg 6'h13 with scird held high: a second read is triggered.
- Quad mismatch: sciaddr[17:9]=9'd1, write request.
  - No strobe, no select, busy stays 0.
- Invalid selector 6, read: err_sel=1, scirmxdata=8'hFF, no pcs strobes.
- Back-to-back traffic: write at N, read at N+1, write at N+2.
  - Read runs directly after the first write's HOLD.
  - Third request dropped; err_ovf=1.
- Reset mid-write: assert rstn=0 during WSTB.
  - pcs_sciwstn=1 and busy=0 immediately; after release, the next request is accepted normally.
